spi_reg_cmd_parser: RTL and testbench

- Byte-level command layer that sits directly downstream of the SPI slave in the i_Clk domain.
- Consumes the slave's RX byte stream (RX_DV/RX_Byte), decodes a 1-byte command plus data bytes, and maintains an 8-bit register bank.
- Produces the TX_DV/TX_Byte pair that the slave serializes onto MISO.
- Frames are delimited by a locally synchronized copy of the SPI chip select.

---
 rtl/spi_reg_cmd_parser_pkg.sv | 29 ++
 rtl/spi_reg_cmd_parser_if.sv | 23 ++
 rtl/spi_reg_cmd_parser_sync_2ff.sv | 24 ++
 rtl/spi_reg_cmd_parser.sv | 162 ++++++++++++++++
 tb/tb_spi_reg_cmd_parser.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_cmd_parser_pkg.sv
// Shared types and constants for the SPI register command parser.
// Status-byte helper is used only when SPI_REG_STATUS_EN is defined.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_CMD     = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  localparam int         CMD_RD_BIT  = 7;
  localparam logic [7:0] TX_WR_FILL  = 8'h00;
  localparam logic [7:0] TX_ERR_FILL = 8'hFF;

  localparam int STAT_ERR_BIT = 7;
  localparam int STAT_CNT_LSB = 0;
  localparam int STAT_CNT_W   = 4;

  function automatic logic [7:0] status_byte(input logic err,
                                             input logic [STAT_CNT_W-1:0] cnt);
    logic [7:0] b;
    b = 8'h00;
    b[STAT_ERR_BIT] = err;
    b[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return b;
  endfunction

endpackage

// File: rtl/spi_reg_cmd_parser_if.sv
// Byte-stream and write/error strobe bundle between the SPI slave side and the parser.
interface spi_reg_cmd_parser_if #(
  parameter int ADDR_W = 4
);
  logic              i_RX_DV;
  logic [7:0]        i_RX_Byte;
  logic              o_TX_DV;
  logic [7:0]        o_TX_Byte;
  logic              o_Wr_Stb;
  logic [ADDR_W-1:0] o_Wr_Addr;
  logic [7:0]        o_Wr_Data;
  logic              o_Err_Stb;

  modport slave (
    input  i_RX_DV, i_RX_Byte,
    output o_TX_DV, o_TX_Byte, o_Wr_Stb, o_Wr_Addr, o_Wr_Data, o_Err_Stb
  );

  modport master (
    output i_RX_DV, i_RX_Byte,
    input  o_TX_DV, o_TX_Byte, o_Wr_Stb, o_Wr_Addr, o_Wr_Data, o_Err_Stb
  );
endinterface

// File: rtl/spi_reg_cmd_parser_sync_2ff.sv
// Generic two-flop synchronizer; both flops reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/spi_reg_cmd_parser.sv
// Command/register layer behind an SPI slave: decodes cmd+data bytes, owns the register bank.
// Define SPI_REG_STATUS_EN to load a status byte into the slave at every CS fall.
module spi_reg_cmd_parser
  import spi_reg_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_SPI_CS_n,
  spi_reg_cmd_parser_if.slave   bus,
  output logic [NUM_REGS*8-1:0] o_Regs
);

  logic              cs_sync;
  logic              cs_prev_q, cs_prev_d;
  logic              cs_rise;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        regs_q [NUM_REGS];
  logic [7:0]        regs_d [NUM_REGS];
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              err_stb_q, err_stb_d;
  logic              addr_ok;

  sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .d     (i_SPI_CS_n),
    .q     (cs_sync)
  );

  assign cs_rise = cs_sync & ~cs_prev_q;
  assign addr_ok = ({1'b0, bus.i_RX_Byte[6:0]} < 8'(NUM_REGS));

`ifdef SPI_REG_STATUS_EN
  logic                  cs_fall;
  logic                  sticky_err_q, sticky_err_d;
  logic [STAT_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  assign cs_fall = ~cs_sync & cs_prev_q;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    regs_d    = regs_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_stb_d = 1'b0;
    cs_prev_d = cs_sync;

    if (bus.i_RX_DV) begin
      unique case (state_q)
        ST_CMD: begin
          if (!addr_ok) begin
            state_d   = ST_DISCARD;
            err_stb_d = 1'b1;
          end else begin
            state_d = bus.i_RX_Byte[CMD_RD_BIT] ? ST_READ : ST_WRITE;
            addr_d  = bus.i_RX_Byte[ADDR_W-1:0];
          end
        end
        ST_WRITE: begin
          regs_d[addr_q] = bus.i_RX_Byte;
          wr_stb_d       = 1'b1;
          wr_addr_d      = addr_q;
          wr_data_d      = bus.i_RX_Byte;
          addr_d         = addr_q + 1'b1;
        end
        ST_READ:    addr_d = addr_q + 1'b1;
        ST_DISCARD: ;
        default:    ;
      endcase

      // Response is chosen from the post-byte state so reads return the auto-incremented address.
      tx_dv_d = 1'b1;
      unique case (state_d)
        ST_READ:    tx_byte_d = regs_q[addr_d];
        ST_DISCARD: tx_byte_d = TX_ERR_FILL;
        default:    tx_byte_d = TX_WR_FILL;
      endcase
    end

    // Frame end wins over the byte's own transition but not over its side effects.
    if (cs_rise) begin
      state_d = ST_CMD;
      addr_d  = '0;
    end

`ifdef SPI_REG_STATUS_EN
    sticky_err_d = sticky_err_q;
    frame_cnt_d  = frame_cnt_q + (cs_rise ? 1'b1 : 1'b0);
    if (cs_fall && !bus.i_RX_DV) begin
      tx_dv_d      = 1'b1;
      tx_byte_d    = status_byte(sticky_err_q, frame_cnt_q);
      sticky_err_d = 1'b0;
    end
    if (err_stb_d) sticky_err_d = 1'b1;
`endif
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cs_prev_q <= 1'b1;
      state_q   <= ST_CMD;
      addr_q    <= '0;
      regs_q    <= '{default: 8'h00};
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      err_stb_q <= 1'b0;
    end else begin
      cs_prev_q <= cs_prev_d;
      state_q   <= state_d;
      addr_q    <= addr_d;
      regs_q    <= regs_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_stb_q <= err_stb_d;
    end
  end

`ifdef SPI_REG_STATUS_EN
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sticky_err_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      sticky_err_q <= sticky_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign o_Regs[8*gi +: 8] = regs_q[gi];
    end
  endgenerate

  assign bus.o_TX_DV   = tx_dv_q;
  assign bus.o_TX_Byte = tx_byte_q;
  assign bus.o_Wr_Stb  = wr_stb_q;
  assign bus.o_Wr_Addr = wr_addr_q;
  assign bus.o_Wr_Data = wr_data_q;
  assign bus.o_Err_Stb = err_stb_q;

endmodule

// File: tb/tb_spi_reg_cmd_parser.sv
// Bench for spi_reg_cmd_parser: directed vector table, CS/reset corner sequences, random frames.
// A frame-level reference model predicts TX bytes, writes, errors and the register bank.
module tb_spi_reg_cmd_parser;

  localparam int N = 16;

`ifdef SPI_REG_STATUS_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cs_n;
  logic [N*8-1:0] regs_flat;

  spi_reg_cmd_parser_if #(.ADDR_W(4)) bus ();

  spi_reg_cmd_parser #(.NUM_REGS(N)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_SPI_CS_n (cs_n),
    .bus        (bus),
    .o_Regs     (regs_flat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed pulses, collected on the falling edge.
  logic [7:0]  act_tx [$];
  logic [11:0] act_wr [$];
  int          act_err = 0;

  // Reference model state.
  logic [7:0]  m_regs [N];
  bit          m_sticky;
  int          m_fc;
  logic [7:0]  exp_tx [$];
  logic [11:0] exp_wr [$];
  int          exp_err;

  logic [7:0]  fb [$];
  logic [7:0]  got_tx [$];
  int          got_wr_n, got_err;

  typedef struct {
    int         n;
    logic [7:0] b  [4];
    logic [7:0] tx [4];
    int         nwr;
    int         nerr;
  } vec_t;
  vec_t vt [5];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_TX_DV)  act_tx.push_back(bus.o_TX_Byte);
      if (bus.o_Wr_Stb) act_wr.push_back({bus.o_Wr_Addr, bus.o_Wr_Data});
      if (bus.o_Err_Stb) act_err++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
    m_sticky = 1'b0;
    m_fc     = 0;
  endtask

  // Whole-frame prediction from the command semantics.
  task automatic model_frame();
    int a;
    exp_tx.delete(); exp_wr.delete(); exp_err = 0;
    if (STAT != 0) begin
      exp_tx.push_back({m_sticky, 3'b000, 4'(m_fc)});
      m_sticky = 1'b0;
    end
    a = int'(fb[0][6:0]);
    if (a >= N) begin
      exp_err = 1;
      m_sticky = 1'b1;
      for (int i = 0; i < fb.size(); i++) exp_tx.push_back(8'hFF);
    end else if (fb[0][7]) begin
      for (int i = 0; i < fb.size(); i++) exp_tx.push_back(m_regs[(a + i) % N]);
    end else begin
      for (int i = 0; i < fb.size(); i++) exp_tx.push_back(8'h00);
      for (int i = 1; i < fb.size(); i++) begin
        m_regs[(a + i - 1) % N] = fb[i];
        exp_wr.push_back({4'((a + i - 1) % N), fb[i]});
      end
    end
    m_fc = (m_fc + 1) % 16;
  endtask

  task automatic compare_frame(input string tag);
    logic [127:0] e;
    check({tag, " tx_count"}, 128'(act_tx.size()), 128'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < act_tx.size(); i++)
      check($sformatf("%s tx[%0d]", tag, i), 128'(act_tx[i]), 128'(exp_tx[i]));
    check({tag, " wr_count"}, 128'(act_wr.size()), 128'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
      check($sformatf("%s wr[%0d]", tag, i), 128'(act_wr[i]), 128'(exp_wr[i]));
    check({tag, " err_count"}, 128'(act_err), 128'(exp_err));
    for (int i = 0; i < N; i++) e[8*i +: 8] = m_regs[i];
    check({tag, " regs"}, regs_flat, e);
  endtask

  task automatic run_frame(input string tag, input bit open_cs, input bit late_cs);
    int gap;
    if (open_cs) cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < fb.size(); i++) begin
      if (late_cs && i == fb.size() - 1) begin
        bus.i_RX_DV = 1'b0;
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
      end
      bus.i_RX_DV   = 1'b1;
      bus.i_RX_Byte = fb[i];
      @(negedge clk);
      bus.i_RX_DV = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end
    bus.i_RX_DV = 1'b0;
    if (!late_cs) cs_n = 1'b1;
    repeat (8) @(negedge clk);
    model_frame();
    compare_frame(tag);
    $display("frame %s: cmd %02h len %0d tx %0d wr %0d err %0d", tag, fb[0], fb.size(),
             act_tx.size(), act_wr.size(), act_err);
    got_tx = act_tx; got_wr_n = act_wr.size(); got_err = act_err;
    act_tx.delete(); act_wr.delete(); act_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_RX_DV = 1'b1; bus.i_RX_Byte = b;
    @(negedge clk);
    bus.i_RX_DV = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vt[0].n = 3; vt[0].b = '{8'h02, 8'hA5, 8'h5A, 8'h00}; vt[0].tx = '{8'h00, 8'h00, 8'h00, 8'h00}; vt[0].nwr = 2; vt[0].nerr = 0;
    vt[1].n = 3; vt[1].b = '{8'h82, 8'h00, 8'h00, 8'h00}; vt[1].tx = '{8'hA5, 8'h5A, 8'h00, 8'h00}; vt[1].nwr = 0; vt[1].nerr = 0;
    vt[2].n = 3; vt[2].b = '{8'h0F, 8'h11, 8'h22, 8'h00}; vt[2].tx = '{8'h00, 8'h00, 8'h00, 8'h00}; vt[2].nwr = 2; vt[2].nerr = 0;
    vt[3].n = 2; vt[3].b = '{8'h20, 8'h77, 8'h00, 8'h00}; vt[3].tx = '{8'hFF, 8'hFF, 8'h00, 8'h00}; vt[3].nwr = 0; vt[3].nerr = 1;
    vt[4].n = 4; vt[4].b = '{8'h8F, 8'h00, 8'h00, 8'h00}; vt[4].tx = '{8'h11, 8'h22, 8'h00, 8'hA5}; vt[4].nwr = 0; vt[4].nerr = 0;

    rst_n = 1'b0; cs_n = 1'b1; bus.i_RX_DV = 1'b0; bus.i_RX_Byte = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset outputs", 128'({bus.o_TX_DV, bus.o_TX_Byte, bus.o_Wr_Stb, bus.o_Wr_Addr,
                                 bus.o_Wr_Data, bus.o_Err_Stb}), 128'(0));
    check("reset regs", regs_flat, 128'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      fb.delete();
      for (int i = 0; i < vt[v].n; i++) fb.push_back(vt[v].b[i]);
      run_frame($sformatf("vec%0d", v), 1'b1, 1'b0);
      for (int i = 0; i < vt[v].n && i + STAT < got_tx.size(); i++)
        check($sformatf("vec%0d table tx[%0d]", v, i), 128'(got_tx[i + STAT]), 128'(vt[v].tx[i]));
      check($sformatf("vec%0d table wr", v), 128'(got_wr_n), 128'(vt[v].nwr));
      check($sformatf("vec%0d table err", v), 128'(got_err), 128'(vt[v].nerr));
`ifdef SPI_REG_STATUS_EN
      if (v == 4 && got_tx.size() > 0) check("status after err bit7", 128'(got_tx[0][7]), 128'(1));
`endif
    end
    check("reg2", 128'(regs_flat[8*2 +: 8]), 128'(8'hA5));
    check("reg3", 128'(regs_flat[8*3 +: 8]), 128'(8'h5A));
    check("reg15 wrap", 128'(regs_flat[8*15 +: 8]), 128'(8'h11));
    check("reg0 wrap", 128'(regs_flat[8*0 +: 8]), 128'(8'h22));

    // CS rises in the very cycle the last write byte is seen.
    fb = '{8'h05, 8'h33};
    run_frame("late_cs", 1'b1, 1'b1);
`ifdef SPI_REG_STATUS_EN
    if (got_tx.size() > 0) check("status cleared bit7", 128'(got_tx[0][7]), 128'(0));
`endif
    check("late_cs reg5", 128'(regs_flat[8*5 +: 8]), 128'(8'h33));
    fb = '{8'h85, 8'h00};
    run_frame("after_late", 1'b1, 1'b0);
    if (got_tx.size() > STAT) check("after_late first tx", 128'(got_tx[STAT]), 128'(8'h33));

    // Reset in the middle of a write burst, frame still active at release.
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h00);
    bus.i_RX_DV = 1'b1; bus.i_RX_Byte = 8'h12;
    @(negedge clk);
    bus.i_RX_DV = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset regs", regs_flat, 128'(0));
    check("midreset strobes", 128'({bus.o_TX_DV, bus.o_Wr_Stb, bus.o_Err_Stb}), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    act_tx.delete(); act_wr.delete(); act_err = 0;
    model_reset();
    fb = '{8'h01, 8'h99};
    run_frame("post_reset", 1'b0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      int len;
      fb.delete();
      fb.push_back({1'($urandom_range(0, 1)), 7'($urandom_range(0, 19))});
      len = $urandom_range(1, 5);
      for (int i = 1; i < len; i++) fb.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", f), 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
